// File: rtl/guess_entry_if.sv
// guess_entry_if: button/scorer inputs and edit/history/status outputs of the guess entry block
interface guess_entry_if;
   logic       btn_inc, btn_sel, btn_submit, game_over;
   logic [1:0] ssd0, ssd1, ssd2, ssd3;
   logic [2:0] edit0, edit1, edit2, edit3;
   logic [1:0] cursor;
   logic [2:0] history0, history1, history2, history3;
   logic       last_turn, guess_strobe;
   logic [3:0] turn;
   logic       won, done;
   modport master (
      output btn_inc, btn_sel, btn_submit, game_over, ssd0, ssd1, ssd2, ssd3,
      input  edit0, edit1, edit2, edit3, cursor, history0, history1, history2, history3,
      input  last_turn, guess_strobe, turn, won, done
   );
   modport slave (
      input  btn_inc, btn_sel, btn_submit, game_over, ssd0, ssd1, ssd2, ssd3,
      output edit0, edit1, edit2, edit3, cursor, history0, history1, history2, history3,
      output last_turn, guess_strobe, turn, won, done
   );
endinterface

// File: rtl/guess_entry.sv
// guess_entry: builds a 4-digit guess from button pulses, commits it to history,
// waits FB_WAIT cycles and samples the scorer pegs to detect a win or game end.
module guess_entry #(
   parameter int MAX_TURNS  = 8,
   parameter int NUM_COLORS = 6,
   parameter int FB_WAIT    = 2
) (
   input logic         clk,
   input logic         rst_n,
   guess_entry_if.slave bus
);
   localparam int CW = FB_WAIT > 1 ? $clog2(FB_WAIT) : 1;
   typedef enum logic [1:0] {EDIT, WAIT_FB, DONE} state_t;
   state_t            state_q, state_d;
   logic [3:0][2:0]   edit_q, edit_d, hist_q, hist_d;
   logic [1:0]        cursor_q, cursor_d;
   logic [3:0]        turn_q, turn_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              last_q, last_d, strobe_q, strobe_d, won_q, won_d, done_q, done_d;
   logic              all_direct;
   assign all_direct = bus.ssd0 == 2'd2 && bus.ssd1 == 2'd2 && bus.ssd2 == 2'd2 && bus.ssd3 == 2'd2;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EDIT;
         edit_q   <= '0;
         hist_q   <= '0;
         cursor_q <= '0;
         turn_q   <= '0;
         cnt_q    <= '0;
         last_q   <= 1'b0;
         strobe_q <= 1'b0;
         won_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         edit_q   <= edit_d;
         hist_q   <= hist_d;
         cursor_q <= cursor_d;
         turn_q   <= turn_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         strobe_q <= strobe_d;
         won_q    <= won_d;
         done_q   <= done_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      edit_d   = edit_q;
      hist_d   = hist_q;
      cursor_d = cursor_q;
      turn_d   = turn_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      strobe_d = 1'b0;
      won_d    = won_q;
      done_d   = done_q;
      case (state_q)
         EDIT: begin
            // submit wins; inc/sel in the same cycle are dropped so the pre-edge guess commits
            if (bus.btn_submit) begin
               hist_d   = edit_q;
               turn_d   = turn_q + 4'd1;
               last_d   = (turn_q + 4'd1) == 4'(MAX_TURNS);
               strobe_d = 1'b1;
               cnt_d    = '0;
               state_d  = WAIT_FB;
            end else begin
               if (bus.btn_inc)
                  edit_d[cursor_q] = edit_q[cursor_q] == 3'(NUM_COLORS - 1) ? 3'd0 : edit_q[cursor_q] + 3'd1;
               if (bus.btn_sel)
                  cursor_d = cursor_q + 2'd1;
            end
         end
         WAIT_FB: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(FB_WAIT - 1)) begin
               won_d   = all_direct;
               done_d  = all_direct || last_q;
               state_d = (all_direct || last_q) ? DONE : EDIT;
            end
         end
         DONE:    state_d = DONE;
         default: state_d = EDIT;
      endcase
      if (bus.game_over) begin
         state_d = DONE;
         done_d  = 1'b1;
      end
   end
   assign bus.edit0        = edit_q[0];
   assign bus.edit1        = edit_q[1];
   assign bus.edit2        = edit_q[2];
   assign bus.edit3        = edit_q[3];
   assign bus.cursor       = cursor_q;
   assign bus.history0     = hist_q[0];
   assign bus.history1     = hist_q[1];
   assign bus.history2     = hist_q[2];
   assign bus.history3     = hist_q[3];
   assign bus.last_turn    = last_q;
   assign bus.guess_strobe = strobe_q;
   assign bus.turn         = turn_q;
   assign bus.won          = won_q;
   assign bus.done         = done_q;
endmodule

// File: tb/tb_guess_entry.sv
// tb_guess_entry: directed checks of editing, commit/settle, win, last turn, game_over and async reset.
module tb_guess_entry;
   localparam int MAXT = 8;
   localparam int NC   = 6;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   logic [2:0]  m_edit [4];
   logic [1:0]  m_cur;
   int          m_turn;
   logic [11:0] m_hist;
   logic        m_last;
   logic [16:0] sb [$];
   logic [16:0] exp_c;
   logic [11:0] pi_vec;
   guess_entry_if bus();
   guess_entry #(.MAX_TURNS(MAXT), .NUM_COLORS(NC), .FB_WAIT(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [11:0] edit_vec();
      return {bus.edit0, bus.edit1, bus.edit2, bus.edit3};
   endfunction
   function automatic logic [11:0] m_pack();
      return {m_edit[0], m_edit[1], m_edit[2], m_edit[3]};
   endfunction
   function automatic logic [63:0] outs();
      return {30'd0, edit_vec(), bus.cursor, bus.history0, bus.history1, bus.history2, bus.history3,
              bus.last_turn, bus.guess_strobe, bus.turn, bus.won, bus.done};
   endfunction
   function automatic logic [63:0] m_outs(input logic w, input logic d);
      return {30'd0, m_pack(), m_cur, m_hist, m_last, 1'b0, 4'(m_turn), w, d};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_edit[i] = 3'd0;
      m_cur = 2'd0; m_turn = 0; m_hist = 12'd0; m_last = 1'b0;
   endtask
   task automatic press(input logic i, input logic s);
      bus.btn_inc = i; bus.btn_sel = s;
      tick();
      bus.btn_inc = 1'b0; bus.btn_sel = 1'b0;
      if (i) m_edit[m_cur] = (m_edit[m_cur] == 3'(NC - 1)) ? 3'd0 : m_edit[m_cur] + 3'd1;
      if (s) m_cur = m_cur + 2'd1;
      check("edit", 64'(edit_vec()), 64'(m_pack()));
      check("cursor", 64'(bus.cursor), 64'(m_cur));
   endtask
   task automatic commit(input logic with_inc);
      sb.push_back({m_turn + 1 == MAXT, 4'(m_turn + 1), m_pack()});
      bus.btn_submit = 1'b1; bus.btn_inc = with_inc;
      tick();
      bus.btn_submit = 1'b0; bus.btn_inc = 1'b0;
      for (int k = 0; k < 4 && bus.guess_strobe !== 1'b1; k++) tick();
      check("strobe_hi", 64'(bus.guess_strobe), 64'd1);
      exp_c = sb.pop_front();
      check("commit", 64'({bus.last_turn, bus.turn, bus.history0, bus.history1, bus.history2, bus.history3}), 64'(exp_c));
      check("edit_kept", 64'(edit_vec()), 64'(m_pack()));
      m_turn++; m_hist = m_pack(); m_last = (m_turn == MAXT);
   endtask
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 check("async_rst", outs(), 64'd0);
      #2 rst_n = 1'b1;
      model_reset();
      tick();
   endtask
   initial begin
      rst_n = 1'b0;
      bus.btn_inc = 1'b0; bus.btn_sel = 1'b0; bus.btn_submit = 1'b0; bus.game_over = 1'b0;
      bus.ssd0 = 2'd0; bus.ssd1 = 2'd0; bus.ssd2 = 2'd0; bus.ssd3 = 2'd0;
      model_reset();
      #12 check("reset", outs(), 64'd0);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         press(1'b1, 1'b0);
         check("edit0_wrap", 64'(bus.edit0), 64'((i + 1) % NC));
      end
      for (int i = 0; i < 4; i++) begin
         press(1'b0, 1'b1);
         check("cursor_wrap", 64'(bus.cursor), 64'((i + 1) % 4));
      end
      repeat (3) press(1'b1, 1'b0);
      press(1'b0, 1'b1); press(1'b1, 1'b0); press(1'b0, 1'b1);
      repeat (4) press(1'b1, 1'b0);
      press(1'b0, 1'b1); press(1'b1, 1'b0); press(1'b0, 1'b1);
      pi_vec = {3'd3, 3'd1, 3'd4, 3'd1};
      check("edit_3141", 64'(edit_vec()), 64'(pi_vec));
      bus.ssd0 = 2'd2; bus.ssd1 = 2'd1;
      commit(1'b0);
      check("hist_3141", 64'({bus.history0, bus.history1, bus.history2, bus.history3}), 64'(pi_vec));
      check("turn1", 64'(bus.turn), 64'd1);
      bus.btn_inc = 1'b1; bus.btn_sel = 1'b1;
      tick();
      check("strobe_lo", 64'(bus.guess_strobe), 64'd0);
      check("wait_ign1", 64'({edit_vec(), bus.cursor}), 64'({m_pack(), m_cur}));
      tick();
      bus.btn_inc = 1'b0; bus.btn_sel = 1'b0;
      check("wait_ign2", 64'({edit_vec(), bus.cursor}), 64'({m_pack(), m_cur}));
      check("settle_nowin", 64'({bus.won, bus.done}), 64'd0);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1); press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      check("edit2_5", 64'(bus.edit2), 64'd5);
      press(1'b1, 1'b1);
      check("sim_edit2", 64'(bus.edit2), 64'd0);
      check("sim_cursor", 64'(bus.cursor), 64'd3);
      commit(1'b1);
      check("turn2", 64'(bus.turn), 64'd2);
      tick(); tick();
      check("back_edit", 64'(bus.done), 64'd0);
      bus.ssd0 = 2'd2; bus.ssd1 = 2'd2; bus.ssd2 = 2'd2; bus.ssd3 = 2'd2;
      commit(1'b0);
      tick();
      check("win_early", 64'(bus.won), 64'd0);
      tick();
      check("win", 64'({bus.won, bus.done}), 64'b11);
      bus.btn_inc = 1'b1; bus.btn_sel = 1'b1; bus.btn_submit = 1'b1;
      tick(); tick();
      bus.btn_inc = 1'b0; bus.btn_sel = 1'b0; bus.btn_submit = 1'b0;
      check("done_hold", outs(), m_outs(1'b1, 1'b1));
      bus.ssd0 = 2'd0; bus.ssd1 = 2'd0; bus.ssd2 = 2'd0; bus.ssd3 = 2'd0;
      do_reset();
      press(1'b1, 1'b0);
      commit(1'b0);
      do_reset();
      press(1'b1, 1'b0);
      bus.game_over = 1'b1;
      tick();
      bus.game_over = 1'b0;
      check("game_over", 64'({bus.won, bus.done}), 64'b01);
      bus.btn_inc = 1'b1;
      tick();
      bus.btn_inc = 1'b0;
      check("go_hold", outs(), m_outs(1'b0, 1'b1));
      do_reset();
      for (int k = 1; k <= MAXT; k++) begin
         press(1'b1, 1'b0);
         commit(1'b0);
         check("last_flag", 64'(bus.last_turn), 64'(k == MAXT));
         tick(); tick();
         check("done_after", 64'(bus.done), 64'(k == MAXT));
      end
      check("turn8", 64'(bus.turn), 64'd8);
      check("last_done", 64'({bus.won, bus.done}), 64'b01);
      press(1'b0, 1'b0);
      bus.btn_submit = 1'b1; bus.btn_inc = 1'b1;
      tick();
      bus.btn_submit = 1'b0; bus.btn_inc = 1'b0;
      check("ninth_ign", outs(), m_outs(1'b0, 1'b1));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
